// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch block fills and LSB loads/stores onto
// a byte-wide synchronous RAM/IO bus, serializing transfers little-endian.
// Optional build macro MEMCTRL_RR_ARB_EN selects round-robin IDLE arbitration
// (default: fixed LSB priority).
module mem_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       BLK_BYTES = 64,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(32'h30000)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   if_valid,
  input  logic [ADDR_W-1:0]      if_addr,
  output logic                   if_done,
  output logic [BLK_BYTES*8-1:0] if_data,
  input  logic                   lsb_valid,
  input  logic                   lsb_wr,
  input  logic [ADDR_W-1:0]      lsb_addr,
  input  logic [1:0]             lsb_len,
  input  logic [31:0]            lsb_wdata,
  output logic                   lsb_done,
  output logic [31:0]            lsb_rdata,
  input  logic [7:0]             mem_din,
  output logic [7:0]             mem_dout,
  output logic [ADDR_W-1:0]      mem_a,
  output logic                   mem_wr,
  input  logic                   io_buffer_full
);

  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = $clog2(BLK_BYTES * 8);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    IF_READ  = 3'd1,
    LS_READ  = 3'd2,
    LS_WRITE = 3'd3,
    STALL    = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    req_len;
  logic [ADDR_W-1:0]   base_addr;
  logic [31:0]         wdata;
  logic [31:0]         rd_buf;

  logic [CNT_W-1:0]    ls_bytes_c;
  logic [CNT_W-1:0]    cap_idx_c;
  logic [IDX_W-1:0]    blk_off_c;
  logic [31:0]         rd_merge_c;
  logic                grant_lsb_c;
  logic                grant_if_c;
  logic                acc_io_c;
  logic                is_io_c;

`ifdef MEMCTRL_RR_ARB_EN
  logic                last_grant_if;
`endif

  // Decode request length, capture index and the word being assembled.
  always_comb begin
    ls_bytes_c = CNT_W'(4);
    case (lsb_len)
      2'd0:    ls_bytes_c = CNT_W'(1);
      2'd1:    ls_bytes_c = CNT_W'(2);
      default: ls_bytes_c = CNT_W'(4);
    endcase
    cap_idx_c  = cnt - CNT_W'(2);
    blk_off_c  = IDX_W'({cap_idx_c, 3'b000});
    rd_merge_c = rd_buf;
    rd_merge_c[{cap_idx_c[1:0], 3'b000} +: 8] = mem_din;
    acc_io_c   = (lsb_addr >= IO_BASE);
    is_io_c    = (base_addr >= IO_BASE);
  end

  // IDLE arbitration between the LSB and the fetch unit.
  always_comb begin
    grant_lsb_c = 1'b0;
    grant_if_c  = 1'b0;
`ifdef MEMCTRL_RR_ARB_EN
    grant_lsb_c = lsb_valid && (!if_valid || last_grant_if);
    grant_if_c  = if_valid && !grant_lsb_c;
`else
    grant_lsb_c = lsb_valid;
    grant_if_c  = if_valid && !lsb_valid;
`endif
  end

  // Transfer FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_len   <= '0;
      base_addr <= '0;
      wdata     <= '0;
      rd_buf    <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr    <= 1'b0;
      if_done   <= 1'b0;
      lsb_done  <= 1'b0;
      if_data   <= '0;
      lsb_rdata <= '0;
`ifdef MEMCTRL_RR_ARB_EN
      last_grant_if <= 1'b1;
`endif
    end else if (rdy) begin
      if_done  <= 1'b0;
      lsb_done <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rollback && grant_lsb_c) begin
            base_addr <= lsb_addr;
            req_len   <= ls_bytes_c;
            wdata     <= lsb_wdata;
            rd_buf    <= '0;
            mem_a     <= lsb_addr;
`ifdef MEMCTRL_RR_ARB_EN
            last_grant_if <= 1'b0;
`endif
            if (lsb_wr) begin
              state <= LS_WRITE;
              // A full IO buffer at acceptance defers byte 0.
              if (acc_io_c && io_buffer_full) begin
                cnt <= '0;
              end else begin
                mem_wr   <= 1'b1;
                mem_dout <= lsb_wdata[7:0];
                cnt      <= CNT_W'(1);
              end
            end else begin
              state <= LS_READ;
              cnt   <= CNT_W'(1);
            end
          end else if (!rollback && grant_if_c) begin
            base_addr <= if_addr;
            req_len   <= CNT_W'(BLK_BYTES);
            mem_a     <= if_addr;
            cnt       <= CNT_W'(1);
            state     <= IF_READ;
`ifdef MEMCTRL_RR_ARB_EN
            last_grant_if <= 1'b1;
`endif
          end
        end
        IF_READ, LS_READ: begin
          if (rollback) begin
            state <= STALL;
            cnt   <= '0;
          end else begin
            // Issue byte cnt while capturing byte cnt-2 (two-cycle RAM latency).
            if (cnt < req_len) begin
              mem_a <= base_addr + ADDR_W'(cnt);
            end
            if (cnt >= CNT_W'(2)) begin
              if (state == IF_READ) begin
                if_data[blk_off_c +: 8] <= mem_din;
              end else begin
                rd_buf <= rd_merge_c;
              end
            end
            if (cnt == req_len + CNT_W'(1)) begin
              state <= STALL;
              cnt   <= '0;
              if (state == IF_READ) begin
                if_done <= 1'b1;
              end else begin
                lsb_done  <= 1'b1;
                lsb_rdata <= rd_merge_c;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        LS_WRITE: begin
          // Stores are committed: rollback is ignored here.
          if (cnt == req_len) begin
            lsb_done <= 1'b1;
            state    <= STALL;
            cnt      <= '0;
          end else if (!(is_io_c && io_buffer_full)) begin
            mem_wr   <= 1'b1;
            mem_a    <= base_addr + ADDR_W'(cnt);
            mem_dout <= wdata[{cnt[1:0], 3'b000} +: 8];
            cnt      <= cnt + CNT_W'(1);
          end
        end
        STALL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder for the instruction-fetch block-fill protocol and the load/store buffer (LSB) request port.
- Arbitrates both requesters onto the single byte-wide synchronous RAM/IO bus.
- Serializes transfers byte by byte, little-endian, and returns whole cache blocks to the fetch unit and 1/2/4-byte words to the LSB.
- Sits between the fetch unit/LSB and the top-level RAM/IO pins.

Parameters:
- ADDR_W, 32, address width.
- BLK_BYTES, 64, bytes per fetch block; if_data width is BLK_BYTES*8.
- IO_BASE, 32'h30000, first IO address; addresses at or above IO_BASE are IO.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- rollback  in  1  speculative flush
- if_valid  in  1  block-fill request, held until if_done
- if_addr  in  ADDR_W  block base address, 64-byte aligned
- if_done  out  1  one-cycle pulse; if_data valid
- if_data  out  BLK_BYTES*8  block; byte k at bits [8k+7:8k]
- lsb_valid  in  1  load/store request, held until lsb_done
- lsb_wr  in  1  1 = store, 0 = load
- lsb_addr  in  ADDR_W  byte address
- lsb_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (3 treated as 4)
- lsb_wdata  in  32  store data, low bytes first
- lsb_done  out  1  one-cycle pulse
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte; valid one cycle after its address is registered
- mem_dout  out  8  write byte
- mem_a  out  ADDR_W  byte address
- mem_wr  out  1  write strobe
- io_buffer_full  in  1  IO write back-pressure

Behaviour:
- Reset: mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0; state=IDLE; byte counter=0.
- States: IDLE, IF_READ, LS_READ, LS_WRITE, STALL.
- IDLE arbitration:
  - If lsb_valid is high, accept the LSB request (fixed LSB priority).
  - Otherwise, if if_valid is high, accept the fetch request.
  - The acceptance edge drives mem_a with byte 0's address.
  - Requests are sampled only at acceptance; the accepted address, length and data are latched.
- Read timing (IF_READ, LS_READ):
  - mem_a increments by 1 each edge while issuing.
  - Byte k is issued at edge E_k and captured from mem_din at E_{k+2} (E_0 = acceptance edge).
  - The done pulse and final data register on the edge that captures the last byte.
  - Fetch fill: if_done is high in the cycle after E_65 (66 cycles after acceptance).
  - N-byte load: lsb_done is high in the cycle after E_{N+1}.
  - Unused lsb_rdata bytes are 0.
- Write timing (LS_WRITE):
  - mem_wr=1, mem_a=addr+k, mem_dout=byte k for the cycle after E_k.
  - lsb_done registers at E_N together with mem_wr<=0.
  - IO write stall: if the address is at or above IO_BASE and io_buffer_full is high, hold mem_wr=0 and do not advance the byte. Resume the cycle after io_buffer_full falls.
- After any done pulse, or an aborted read, enter STALL for exactly 1 cycle, then IDLE. Requesters drop valid on the edge that samples done, so no request is re-accepted.
- Rollback:
  - In IF_READ or LS_READ: abort on that edge, suppress done even if it coincides with the final capture, and go to STALL.
  - LS_WRITE is committed and is never aborted.
  - In IDLE: no request is accepted that edge.
- mem_wr is 0 in every state except LS_WRITE.
- Counter wrap: the byte counter is 7 bits; addresses do not wrap inside a block because if_addr is aligned.
- Reset mid-transfer: immediate return to the reset values; no done pulse is produced.

Optional Feature:
- MEMCTRL_RR_ARB_EN: when defined, IDLE arbitration is round-robin. A last_grant bit favours the requester not served last; on reset the LSB is favoured.
- When undefined: fixed LSB priority, and the fetch unit is served only when lsb_valid is low in IDLE.

Test Plan:
- Reset: assert rst for 2 cycles → all outputs 0, mem_wr=0, no done pulses for 10 idle cycles.
- Block fill: RAM[i]=i[7:0]; if_valid, if_addr=0x1000 → mem_a sweeps 0x1000..0x103F; if_done for exactly 1 cycle, 66 cycles after acceptance; if_data byte k == (0x1000+k)&0xFF.
- Contention: if_valid and lsb_valid rise together; load 4 bytes at 0x1002 → LSB served first with lsb_rdata=0x05040302 and lsb_done 6 cycles after acceptance; 1-cycle STALL; fetch is accepted the next cycle.
- IO store: 2-byte store 0xBEEF to 0x30000, io_buffer_full high for 3 cycles → mem_wr stays 0 for those cycles; then 0xEF is written to 0x30000 and 0xBE to 0x30001; lsb_done follows.
- Rollback: pulse rollback after 20 bytes of a fill → no if_done, mem_wr stays 0; STALL then IDLE; a new fill at 0x2000 completes normally.
- With MEMCTRL_RR_ARB_EN: back-to-back requests from both requesters held continuously → grants alternate LSB, IF, LSB, IF.
